// File: rtl/fb_pkg.sv
// Shared types and sizing for the filter/bias store behind the DMA.
package fb_pkg;
  localparam int K           = 5;
  localparam int MAX_FILTERS = 16;
  localparam int BIAS_DEPTH  = 120;
  localparam int BIAS_CHUNK  = 8;
  localparam int NCHUNK      = BIAS_DEPTH / BIAS_CHUNK;
  localparam int SLOT_W      = $clog2(MAX_FILTERS);
  localparam int ROW_W       = $clog2(K);
  localparam int CNT_W       = $clog2(NCHUNK);
  localparam int BIDX_W      = $clog2(BIAS_DEPTH);

  typedef logic signed [15:0]        word_t;
  typedef word_t [0:K-1]             row_t;
  typedef row_t  [0:K-1]             window_t;
  typedef word_t [0:BIAS_DEPTH-1]    bias_vec_t;
  typedef word_t [0:BIAS_CHUNK-1]    chunk_t;

  typedef enum logic [1:0] {IDLE, WR_FILT, WR_BIAS, DONE} fb_state_t;

  typedef struct packed {
    logic  vld;
    word_t fidx;
    word_t bidx;
  } rd_req_t;
endpackage

// File: rtl/fb_write_ctrl.sv
// Write FSM: stages one DMA request, then streams it into storage a row or chunk per cycle.
module fb_write_ctrl
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              FB_write,
  input  logic              FB_bias_or_filter,
  input  word_t             FB_index_filter,
  input  window_t           FB_filter,
  input  bias_vec_t         FB_bias,
  output logic              FB_finish,
  output logic              FB_error,
  output logic              filt_we,
  output logic [SLOT_W-1:0] filt_slot,
  output logic [ROW_W-1:0]  filt_row,
  output row_t              filt_data,
  output logic              filt_commit,
  output logic              bias_we,
  output logic [CNT_W-1:0]  bias_chunk,
  output chunk_t            bias_data
);
  fb_state_t         state, state_n;
  window_t           stg_f;
  bias_vec_t         stg_b;
  logic [SLOT_W-1:0] slot_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fin_q, err_q;
  logic              idx_ok;

  assign idx_ok = !FB_index_filter[15] && (FB_index_filter < 16'(MAX_FILTERS));

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (FB_write) state_n = !FB_bias_or_filter ? WR_BIAS : (idx_ok ? WR_FILT : DONE);
      WR_FILT: if (cnt_q == CNT_W'(K-1)) state_n = DONE;
      WR_BIAS: if (cnt_q == CNT_W'(NCHUNK-1)) state_n = DONE;
      DONE:    if (!FB_write) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_f  <= '0;
      stg_b  <= '0;
      slot_q <= '0;
      cnt_q  <= '0;
      fin_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && FB_write) begin
        if (FB_bias_or_filter) begin
          stg_f  <= FB_filter;
          slot_q <= FB_index_filter[SLOT_W-1:0];
        end else begin
          stg_b  <= FB_bias;
        end
      end
      // counter only advances while streaming; every state change restarts it
      cnt_q <= (state_n == state && (state == WR_FILT || state == WR_BIAS)) ? cnt_q + 1'b1 : '0;
      fin_q <= (state_n == DONE);
      err_q <= (state == IDLE) ? (FB_write && FB_bias_or_filter && !idx_ok)
                               : (err_q && state_n == DONE);
    end
  end

  assign FB_finish   = fin_q;
  assign FB_error    = err_q;
  assign filt_we     = (state == WR_FILT);
  assign filt_slot   = slot_q;
  assign filt_row    = cnt_q[ROW_W-1:0];
  assign filt_data   = stg_f[filt_row];
  assign filt_commit = filt_we && (cnt_q == CNT_W'(K-1));
  assign bias_we     = (state == WR_BIAS);
  assign bias_chunk  = cnt_q;
  assign bias_data   = stg_b[(BIDX_W'(cnt_q) << $clog2(BIAS_CHUNK)) +: BIAS_CHUNK];
endmodule

// File: rtl/filter_bias_buffer.sv
// Filter/bias storage with a registered read port; reads of a slot mid-write wait for the commit.
module filter_bias_buffer
  import fb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   FB_write,
  input  logic                   FB_bias_or_filter,
  input  word_t                  FB_index_filter,
  input  window_t                FB_filter,
  input  bias_vec_t              FB_bias,
  output logic                   FB_finish,
  output logic                   FB_error,
  input  logic                   rd_en,
  input  word_t                  rd_filter_idx,
  input  word_t                  rd_bias_idx,
  output logic                   rd_valid,
  output window_t                rd_filter,
  output word_t                  rd_bias,
  output logic [MAX_FILTERS-1:0] filter_valid
);
  logic              filt_we, filt_commit, bias_we;
  logic [SLOT_W-1:0] filt_slot;
  logic [ROW_W-1:0]  filt_row;
  row_t              filt_data;
  logic [CNT_W-1:0]  bias_chunk;
  chunk_t            bias_data;
  logic [BIDX_W-1:0] bias_base;

  window_t   filt_mem [MAX_FILTERS];
  bias_vec_t bias_mem;
  rd_req_t   req_q;
  logic      hazard, serve, fidx_ok, bidx_ok;

  fb_write_ctrl u_ctrl (
    .clk, .reset, .FB_write, .FB_bias_or_filter, .FB_index_filter, .FB_filter, .FB_bias,
    .FB_finish, .FB_error, .filt_we, .filt_slot, .filt_row, .filt_data, .filt_commit,
    .bias_we, .bias_chunk, .bias_data
  );

  assign bias_base = BIDX_W'(bias_chunk) << $clog2(BIAS_CHUNK);
  // the whole window is returned at once, so a slot is unreadable until its last row lands
  assign hazard  = req_q.vld && filt_we && (req_q.fidx == 16'(filt_slot));
  assign serve   = req_q.vld && !hazard;
  assign fidx_ok = !req_q.fidx[15] && (req_q.fidx < 16'(MAX_FILTERS));
  assign bidx_ok = !req_q.bidx[15] && (req_q.bidx < 16'(BIAS_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_FILTERS; i++) filt_mem[i] <= '0;
      bias_mem     <= '0;
      filter_valid <= '0;
      req_q        <= '0;
      rd_valid     <= 1'b0;
      rd_filter    <= '0;
      rd_bias      <= '0;
    end else begin
      if (filt_we)     filt_mem[filt_slot][filt_row] <= filt_data;
      if (filt_commit) filter_valid[filt_slot] <= 1'b1;
      if (bias_we)
        for (int j = 0; j < BIAS_CHUNK; j++) bias_mem[bias_base + BIDX_W'(j)] <= bias_data[j];
      if (!req_q.vld || serve) req_q <= '{vld: rd_en, fidx: rd_filter_idx, bidx: rd_bias_idx};
      rd_valid <= serve;
      if (serve) begin
        rd_filter <= fidx_ok ? filt_mem[req_q.fidx[SLOT_W-1:0]] : '0;
        rd_bias   <= bidx_ok ? bias_mem[req_q.bidx[BIDX_W-1:0]] : '0;
      end
    end
  end
endmodule

// File: tb/tb_filter_bias_buffer.sv
// Randomized bench for filter_bias_buffer against an array model of the store.
module tb_filter_bias_buffer;
  import fb_pkg::*;

  logic                   clk = 1'b0, reset = 1'b0;
  logic                   FB_write = 1'b0, FB_bias_or_filter = 1'b0;
  word_t                  FB_index_filter = '0;
  window_t                FB_filter = '0;
  bias_vec_t              FB_bias = '0;
  logic                   FB_finish, FB_error;
  logic                   rd_en = 1'b0;
  word_t                  rd_filter_idx = '0, rd_bias_idx = '0;
  logic                   rd_valid;
  window_t                rd_filter;
  word_t                  rd_bias;
  logic [MAX_FILTERS-1:0] filter_valid;

  always #5 clk = ~clk;

  filter_bias_buffer dut (
    .clk(clk), .reset(reset), .FB_write(FB_write), .FB_bias_or_filter(FB_bias_or_filter),
    .FB_index_filter(FB_index_filter), .FB_filter(FB_filter), .FB_bias(FB_bias),
    .FB_finish(FB_finish), .FB_error(FB_error), .rd_en(rd_en), .rd_filter_idx(rd_filter_idx),
    .rd_bias_idx(rd_bias_idx), .rd_valid(rd_valid), .rd_filter(rd_filter), .rd_bias(rd_bias),
    .filter_valid(filter_valid)
  );

  int n_err = 0, n_chk = 0;
  int fm [MAX_FILTERS][K][K];
  int bm [BIAS_DEPTH];
  logic [MAX_FILTERS-1:0] fv = '0;
  int wv [K][K];
  int bvv [BIAS_DEPTH];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < MAX_FILTERS; s++)
      for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) fm[s][r][c] = 0;
    for (int i = 0; i < BIAS_DEPTH; i++) bm[i] = 0;
    fv = '0;
  endtask

  task automatic rand_window();
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) wv[r][c] = rnd16();
  endtask

  task automatic rand_bias();
    for (int i = 0; i < BIAS_DEPTH; i++) bvv[i] = rnd16();
  endtask

  task automatic drive_data();
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) FB_filter[r][c] = 16'(wv[r][c]);
    for (int i = 0; i < BIAS_DEPTH; i++) FB_bias[i] = 16'(bvv[i]);
  endtask

  task automatic scramble();
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) FB_filter[r][c] = 16'($urandom);
    for (int i = 0; i < BIAS_DEPTH; i++) FB_bias[i] = 16'($urandom);
    FB_index_filter   = 16'($urandom);
    FB_bias_or_filter = 1'($urandom);
  endtask

  task automatic check_window(input string tag, input int fi);
    bit ok = (fi >= 0 && fi < MAX_FILTERS);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        check(tag, int'($signed(rd_filter[r][c])), ok ? fm[fi][r][c] : 0);
  endtask

  // full write transaction: request, count edges to finish, optional hold, release
  task automatic wr(input bit is_f, input int idx, input int hold);
    int e = 0;
    bit ok = !is_f || (idx >= 0 && idx < MAX_FILTERS);
    int exp_e = !is_f ? NCHUNK + 1 : (ok ? K + 1 : 1);
    drive_data();
    FB_bias_or_filter = is_f;
    FB_index_filter   = 16'(idx);
    FB_write          = 1'b1;
    do begin
      tick(); e++;
      if (e == 1) scramble();
    end while (!FB_finish && e < 64);
    check("wr_latency", e, exp_e);
    check("wr_error", int'(FB_error), int'(!ok));
    if (ok) begin
      if (is_f) begin
        for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) fm[idx][r][c] = wv[r][c];
        fv[idx] = 1'b1;
      end else begin
        for (int i = 0; i < BIAS_DEPTH; i++) bm[i] = bvv[i];
      end
    end
    for (int h = 0; h < hold; h++) begin
      scramble(); tick();
      check("wr_hold_finish", int'(FB_finish), 1);
    end
    FB_write = 1'b0;
    tick();
    check("wr_drop_finish", int'(FB_finish), 0);
    check("wr_drop_error", int'(FB_error), 0);
    check("filter_valid", int'(filter_valid), int'(fv));
  endtask

  task automatic rd(input int fi, input int bi);
    rd_filter_idx = 16'(fi);
    rd_bias_idx   = 16'(bi);
    rd_en         = 1'b1;
    tick();
    check("rd_early", int'(rd_valid), 0);
    rd_en = 1'b0;
    rd_filter_idx = 16'($urandom);
    rd_bias_idx   = 16'($urandom);
    tick();
    check("rd_valid", int'(rd_valid), 1);
    check_window("rd_filter", fi);
    check("rd_bias", int'(rd_bias), (bi >= 0 && bi < BIAS_DEPTH) ? bm[bi] : 0);
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < BIAS_DEPTH; i++) bvv[i] = 0;
    tick(); tick();
    check("rst_finish", int'(FB_finish), 0);
    check("rst_error", int'(FB_error), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_filter_valid", int'(filter_valid), 0);
    check("rst_rd_bias", int'(rd_bias), 0);
    check("rst_rd_filter_zero", int'(rd_filter == '0), 1);
    reset = 1'b1;
    tick();

    // directed filter write, slot 3
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) wv[r][c] = 10 * r + c;
    wr(1'b1, 3, 0);
    check("fv_slot3", int'(filter_valid), 16'h0008);
    rd(3, 0);
    check("rd_f44", int'($signed(rd_filter[4][4])), 44);

    // directed bias write
    for (int i = 0; i < BIAS_DEPTH; i++) bvv[i] = i - 60;
    wr(1'b0, 0, 0);
    rd(3, 0);   check("bias0", int'(rd_bias), -60);
    rd(3, 7);   check("bias7", int'(rd_bias), -53);
    rd(3, 8);   check("bias8", int'(rd_bias), -52);
    rd(3, 119); check("bias119", int'(rd_bias), 59);
    rd(16, 120);
    rd(-1, -1);

    // held handshake, then re-raise for a fresh write to the same slot
    rand_window(); wr(1'b1, 9, 5); rd(9, 1);
    rand_window(); wr(1'b1, 9, 0); rd(9, 2);

    // out of range indices leave storage and flags alone
    rand_window(); wr(1'b1, 16, 0);
    rand_window(); wr(1'b1, -1, 2);
    rd(3, 5); rd(9, 6);

    // read hazard on the slot being written
    rand_window(); wr(1'b1, 5, 0);
    rand_window(); drive_data();
    FB_bias_or_filter = 1'b1; FB_index_filter = 16'(5); FB_write = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) scramble();
      if (e == 2)      begin rd_filter_idx = 16'(5); rd_bias_idx = 16'(0); rd_en = 1'b1; end
      else if (e == 3) begin rd_filter_idx = 16'(0); rd_en = 1'b1; end
      else rd_en = 1'b0;
      if (e <= 6) check("hz_no_valid", int'(rd_valid), 0);
      if (e == 6) begin
        check("hz_finish", int'(FB_finish), 1);
        for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) fm[5][r][c] = wv[r][c];
        fv[5] = 1'b1;
      end
      if (e == 7) begin
        check("hz_valid", int'(rd_valid), 1);
        check_window("hz_data", 5);
        check("hz_bias", int'(rd_bias), bm[0]);
      end
      if (e == 8) check("hz_second_dropped", int'(rd_valid), 0);
    end
    FB_write = 1'b0;
    tick();
    check("hz_drop_finish", int'(FB_finish), 0);
    check("hz_fv", int'(filter_valid), int'(fv));

    // randomized traffic
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rand_bias(); wr(1'b0, 0, int'($urandom_range(0, 2)));
      end else begin
        rand_window(); wr(1'b1, int'($urandom_range(0, 19)) - 2, int'($urandom_range(0, 2)));
      end
      rd(int'($urandom_range(0, 19)) - 2, int'($urandom_range(0, 123)) - 2);
      rd(int'($urandom_range(0, 15)), int'($urandom_range(0, 119)));
    end

    // reset in the middle of a bias write with a read landing
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) wv[r][c] = 100 + r;
    wr(1'b1, 3, 0);
    rand_bias(); drive_data();
    FB_bias_or_filter = 1'b0; FB_write = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) begin rd_filter_idx = 16'(3); rd_bias_idx = 16'(5); rd_en = 1'b1; end
      else rd_en = 1'b0;
    end
    check("mid_rd_valid_pre", int'(rd_valid), 1);
    reset = 1'b0;
    #1;
    check("mid_finish", int'(FB_finish), 0);
    check("mid_error", int'(FB_error), 0);
    check("mid_rd_valid", int'(rd_valid), 0);
    check("mid_rd_bias", int'(rd_bias), 0);
    check("mid_rd_filter_zero", int'(rd_filter == '0), 1);
    check("mid_filter_valid", int'(filter_valid), 0);
    FB_write = 1'b0;
    model_clear();
    tick();
    reset = 1'b1;
    tick();
    rd(3, 5); rd(0, 119); rd(3, 0);
    rand_window(); wr(1'b1, 2, 0);
    rd(2, 64);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/filter_bias_buffer.md
Name: filter_bias_buffer

Overview:
- Filter/bias store directly downstream of the DMA. It consumes the DMA's FB_* write handshake: one 5x5 filter at a time, or one full 120-entry bias vector.
- It holds up to MAX_FILTERS filters plus the bias vector, and serves 1-cycle-latency reads to the convolution engine.
- Writes are multi-cycle: one filter row per cycle, or BIAS_CHUNK bias words per cycle. This models narrow physical storage.

Parameters:
- MAX_FILTERS, 16: number of filter slots.
- K, 5: filter side (5x5 window).
- BIAS_DEPTH, 120: bias vector length.
- BIAS_CHUNK, 8: bias words committed per cycle (BIAS_DEPTH/BIAS_CHUNK = 15 cycles).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- FB_write  in  1  write request (level; held until FB_finish seen)
- FB_bias_or_filter  in  1  1 = filter write, 0 = bias write
- FB_index_filter  in  shortint  target filter slot
- FB_filter  in  shortint [0:K-1][0:K-1]  filter data
- FB_bias  in  shortint [0:BIAS_DEPTH-1]  bias data
- FB_finish  out  1  write complete
- FB_error  out  1  valid with FB_finish; index out of range, nothing written
- rd_en  in  1  read request
- rd_filter_idx  in  shortint  filter slot to read
- rd_bias_idx  in  shortint  bias entry to read
- rd_valid  out  1  read data valid
- rd_filter  out  shortint [0:K-1][0:K-1]  filter read data
- rd_bias  out  shortint  bias read data
- filter_valid  out  MAX_FILTERS  per-slot written flag

Behaviour:
- Reset (async, reset=0) clears:
  - FSM → IDLE
  - FB_finish, FB_error, rd_valid = 0
  - rd_filter, rd_bias = 0
  - filter_valid = 0
  - all filter and bias storage = 0
  - pending read cleared
- Reset mid-write aborts the write. After release, the block is IDLE with empty storage.
- FSM states: IDLE, WR_FILT, WR_BIAS, DONE.
- IDLE, FB_write=1 sampled:
  - Filter write, index in 0..MAX_FILTERS-1: latch FB_filter and index into staging, row counter = 0, go to WR_FILT.
  - Filter write, index out of range (including negative): go to DONE with FB_error=1; nothing written.
  - Bias write: latch FB_bias into staging, chunk counter = 0, go to WR_BIAS.
- WR_FILT: each cycle copy staging row r into slot[index] row r.
  - After row K-1, set filter_valid[index] and go to DONE.
  - FB_finish goes high after the 6th rising edge, counting the acceptance edge as the 1st.
- WR_BIAS: each cycle copy BIAS_CHUNK words (entries chunk*8 .. chunk*8+7).
  - After chunk 14, go to DONE. FB_finish goes high after the 16th edge.
- DONE: FB_finish=1; FB_error holds its value.
  - Stay in DONE while FB_write=1.
  - When FB_write=0 is sampled, go to IDLE and clear FB_finish and FB_error (four-phase handshake).
  - A new request needs FB_write low for at least one cycle.
- Inputs change during WR_*: ignored, because data comes from staging.
- Reads:
  - rd_en sampled at edge N gives rd_valid=1 and data for exactly one cycle after edge N+1 (1-cycle latency).
  - Reads run concurrently with writes.
  - Out-of-range rd_filter_idx or rd_bias_idx returns zeros with rd_valid=1.
- Hazard: rd_en with rd_filter_idx equal to the in-flight slot during WR_FILT:
  - The request is held pending; later rd_en pulses are ignored while a read is pending.
  - It is served with committed data on the cycle after DONE entry.
- Reads of bias during WR_BIAS return mixed old/new data. This is documented and is not a hazard.
- Rewriting a valid slot overwrites it; filter_valid stays 1.

Decomposition:
- Package fb_pkg:
  - constants K, MAX_FILTERS, BIAS_DEPTH, BIAS_CHUNK
  - typedef window_t (shortint [0:K-1][0:K-1])
  - typedef bias_vec_t
  - enum fb_state_t
- One sub-module: fb_write_ctrl (FSM, counters, staging, handshake). Storage and the read port stay in the top level.

Test Plan:
- Filter write: index=3, FB_filter[r][c]=10*r+c, FB_write held → FB_finish rises 6 edges after acceptance; filter_valid=0x0008; read idx 3 → rd_filter[4][4]=44 one cycle after rd_en.
- Bias write: FB_bias[i]=i-60 → FB_finish after 16 edges; reads of entries 0, 7, 8, 119 return -60, -53, -52, 59.
- Handshake: hold FB_write 5 cycles past FB_finish → FB_finish stays 1 and no second write occurs; drop FB_write → FB_finish=0 next edge; re-raise → new write accepted.
- Out-of-range: index=16 → FB_finish=1 with FB_error=1; filter_valid unchanged; storage unchanged.
- Hazard: rd_en idx=5 two cycles into a write to slot 5 → rd_valid only after DONE, returning new data.
- Reset mid-write: reset=0 during WR_BIAS chunk 7 → all outputs 0 immediately; afterwards bias reads return 0 and a fresh filter write completes normally.
